// File: rtl/gcd_arb_pkg.sv
// rtl/gcd_arb_pkg.sv - shared constants and FSM state type for the gcd arbiter
package gcd_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// rtl/gcd_rr_arbiter.sv - combinational round-robin pick: lowest requesting index at or after i_rr_ptr
module gcd_rr_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_grant
);

  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    w_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = {1'b0, i_rr_ptr} + SUM_W'(i);
      if (w_idx >= SUM_W'(NUM_REQ)) begin
        w_idx = w_idx - SUM_W'(NUM_REQ);
      end
      if (i_req[w_idx[IDX_W-1:0]]) begin
        o_valid = 1'b1;
        o_grant = w_idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - shares one gcd core among NUM_REQ requesters, one transaction in flight
// Optional macro GCD_ARB_ZERO_BYPASS_EN: zero-operand requests are answered (a|b) without the core.
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic                        core_start,
  output logic [DATA_W-1:0]           core_a,
  output logic [DATA_W-1:0]           core_b,
  input  logic                        core_idle,
  input  logic                        core_done,
  input  logic [DATA_W-1:0]           core_result,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t            r_state;
  state_t            w_next_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_grant_id;
  logic [DATA_W-1:0] r_core_a;
  logic [DATA_W-1:0] r_core_b;
  logic [DATA_W-1:0] r_rsp_data;
  logic              w_arb_valid;
  logic [IDX_W-1:0]  w_arb_grant;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic              w_accept;
  logic              w_bypass;
  logic              w_rsp_fire;
  logic [IDX_W-1:0]  w_next_ptr;

  gcd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_arb_valid),
    .o_grant  (w_arb_grant)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_grant == IDX_W'(i)) begin
        w_sel_a = req_a[i*DATA_W +: DATA_W];
        w_sel_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef GCD_ARB_ZERO_BYPASS_EN
  assign w_bypass = (w_sel_a == '0) || (w_sel_b == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_accept   = (r_state == ST_IDLE) && w_arb_valid;
  assign w_rsp_fire = (r_state == ST_RESP) && rsp_ready[r_grant_id];
  assign w_next_ptr = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Combinational handshakes are forced low while reset is held.
  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    rsp_valid    = '0;
    core_start   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          req_ready[w_arb_grant] = 1'b1;
          w_next_state = w_bypass ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (core_idle) begin
          core_start   = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_done) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid[r_grant_id] = 1'b1;
        if (rsp_ready[r_grant_id]) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (sys_rst) begin
      req_ready  = '0;
      rsp_valid  = '0;
      core_start = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_core_a   <= '0;
      r_core_b   <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_grant_id <= w_arb_grant;
        r_core_a   <= w_sel_a;
        r_core_b   <= w_sel_b;
        if (w_bypass) begin
          r_rsp_data <= w_sel_a | w_sel_b;
        end
      end
      if ((r_state == ST_WAIT) && core_done) begin
        r_rsp_data <= core_result;
      end
      if (w_rsp_fire) begin
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  assign core_a   = r_core_a;
  assign core_b   = r_core_b;
  assign rsp_data = r_rsp_data;
  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb/tb_gcd_arbiter.sv - randomized self-checking bench for gcd_arbiter with a behavioural gcd core
module tb_gcd_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           sys_clk;
  logic           sys_rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [N-1:0]   rsp_ready;
  logic           core_start;
  logic [W-1:0]   core_a;
  logic [W-1:0]   core_b;
  logic           core_idle;
  logic           core_done;
  logic [W-1:0]   core_result;
  logic           busy;
  logic [1:0]     grant_id;

  gcd_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_ready   (rsp_ready),
    .core_start  (core_start),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_idle   (core_idle),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;
  int core_lat = 2;
  bit stall_idle = 0;
  int n_starts = 0;
  bit m_busy = 0;
  int m_cnt = 0;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int exp_grant(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  // Behavioural core: busy for core_lat+1 cycles after a start, then one-cycle done.
  initial begin
    core_idle = 1'b1;
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(negedge sys_clk);
      #1;
      core_done = 1'b0;
      if (m_busy) begin
        if (m_cnt == 0) begin
          core_done = 1'b1;
          core_result = gcd_ref(m_a, m_b);
          m_busy = 0;
        end else begin
          m_cnt--;
        end
      end
      core_idle = !m_busy && !stall_idle;
      #1;
      if (core_start === 1'b1) begin
        m_busy = 1;
        m_cnt = core_lat;
        m_a = core_a;
        m_b = core_b;
        n_starts++;
      end
    end
  end

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  endtask

  task automatic rand_ops();
    int k;
    for (int i = 0; i < N; i++) begin
      k = $urandom_range(1, 500);
      op_a[i] = k * $urandom_range(1, 1000);
      op_b[i] = k * $urandom_range(1, 1000);
    end
    drive_ops();
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    m_ptr = 0;
  endtask

  // Runs one transaction and reports observations; the calling test does the comparing.
  task automatic do_txn(input logic [N-1:0] mask, input logic [N-1:0] hold, input int delay,
                        output int g, output logic [W-1:0] data, output logic [N-1:0] onehot,
                        output logic [N-1:0] after, output bit stable);
    int t;
    g = -1; data = '0; onehot = '0; after = '1; stable = 1;
    t = 0;
    do begin
      @(negedge sys_clk);
      req_valid = mask;
      rsp_ready = '0;
      #3;
      t++;
    end while (req_ready == '0 && t < 50);
    if (req_ready == '0) return;
    g = -2;
    if ($countones(req_ready) == 1) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
    end
    @(negedge sys_clk);
    req_valid = hold;
    #3;
    after = req_ready;
    t = 0;
    while (rsp_valid == '0 && t < 300) begin
      @(negedge sys_clk);
      #3;
      t++;
    end
    if (rsp_valid == '0) return;
    onehot = rsp_valid;
    data = rsp_data;
    repeat (delay) begin
      @(negedge sys_clk);
      rsp_ready = ~onehot;
      #3;
      if (rsp_valid !== onehot || rsp_data !== data || req_ready !== '0) stable = 0;
    end
    @(negedge sys_clk);
    rsp_ready = '1;
    #3;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    req_valid = '1;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(negedge sys_clk);
    #3;
    n_vec++;
    if (req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    n_vec++;
    if (busy !== 1'b0 || core_start !== 1'b0 || rsp_valid !== '0 || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: busy=%b core_start=%b rsp_valid=%b grant_id=%0d expected all 0", busy, core_start, rsp_valid, grant_id);
    end
    n_vec++;
    if (core_a !== '0 || core_b !== '0 || rsp_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: core_a=%0d core_b=%0d rsp_data=%0d expected 0", core_a, core_b, rsp_data);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    req_valid = '0;
    m_ptr = 0;
  endtask

  task automatic test_single();
    int g, e, s0;
    logic [W-1:0] d;
    logic [N-1:0] oh, aft;
    bit st;
    op_a[1] = 48;
    op_b[1] = 18;
    drive_ops();
    e = exp_grant(4'b0010);
    s0 = n_starts;
    do_txn(4'b0010, 4'b0000, 0, g, d, oh, aft, st);
    n_vec++;
    if (g !== e) begin n_err++; $display("FAIL single_grant: got %0d expected %0d", g, e); end
    n_vec++;
    if (n_starts - s0 !== 1) begin n_err++; $display("FAIL single_starts: got %0d expected 1", n_starts - s0); end
    n_vec++;
    if (m_a !== 48 || m_b !== 18) begin n_err++; $display("FAIL single_operands: got %0d,%0d expected 48,18", m_a, m_b); end
    n_vec++;
    if (oh !== 4'b0010 || d !== 32'd6) begin n_err++; $display("FAIL single_rsp: got valid=%b data=%0d expected 0010/6", oh, d); end
    m_ptr = (e + 1) % N;
  endtask

  task automatic test_round_robin();
    int g, e;
    logic [W-1:0] d;
    logic [N-1:0] oh, aft;
    bit st;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      e = exp_grant(4'hF);
      do_txn(4'hF, 4'hF, 0, g, d, oh, aft, st);
      n_vec++;
      if (g !== e || e !== k % N) begin n_err++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, g, k % N); end
      n_vec++;
      if (aft !== '0) begin n_err++; $display("FAIL rr_ready_pulse[%0d]: got %b expected 0000", k, aft); end
      n_vec++;
      if (d !== gcd_ref(op_a[e], op_b[e])) begin n_err++; $display("FAIL rr_data[%0d]: got %0d expected %0d", k, d, gcd_ref(op_a[e], op_b[e])); end
      m_ptr = (e + 1) % N;
    end
    req_valid = '0;
  endtask

  task automatic test_core_stall();
    int e, s0, pulses, t;
    op_a[3] = 100;
    op_b[3] = 75;
    drive_ops();
    e = exp_grant(4'b1000);
    s0 = n_starts;
    @(negedge sys_clk);
    stall_idle = 1;
    req_valid = 4'b1000;
    rsp_ready = '0;
    #3;
    n_vec++;
    if (req_ready !== 4'b1000) begin n_err++; $display("FAIL stall_accept: got %b expected 1000", req_ready); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      req_valid = '0;
      #3;
      if (core_start === 1'b1 || busy !== 1'b1) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin n_err++; $display("FAIL stall_hold: got %0d bad cycles expected 0", pulses); end
    @(negedge sys_clk);
    stall_idle = 0;
    #3;
    t = 0;
    while (rsp_valid == '0 && t < 100) begin
      if (core_start === 1'b1) pulses++;
      @(negedge sys_clk);
      #3;
      t++;
    end
    n_vec++;
    if (pulses !== 1 || n_starts - s0 !== 1) begin n_err++; $display("FAIL stall_start: got %0d pulses expected 1", pulses); end
    n_vec++;
    if (rsp_valid !== 4'b1000 || rsp_data !== 32'd25) begin n_err++; $display("FAIL stall_rsp: got %b/%0d expected 1000/25", rsp_valid, rsp_data); end
    @(negedge sys_clk);
    rsp_ready = '1;
    m_ptr = (e + 1) % N;
  endtask

  task automatic test_resp_backpressure();
    int g, e;
    logic [W-1:0] d;
    logic [N-1:0] oh, aft;
    bit st;
    rand_ops();
    e = exp_grant(4'b0100);
    do_txn(4'b0100, 4'hF, 10, g, d, oh, aft, st);
    n_vec++;
    if (g !== 2 || e !== 2) begin n_err++; $display("FAIL bp_grant: got %0d expected 2", g); end
    n_vec++;
    if (st !== 1'b1 || oh !== 4'b0100) begin n_err++; $display("FAIL bp_stable: got stable=%0d valid=%b expected 1/0100", st, oh); end
    n_vec++;
    if (d !== gcd_ref(op_a[2], op_b[2])) begin n_err++; $display("FAIL bp_data: got %0d expected %0d", d, gcd_ref(op_a[2], op_b[2])); end
    m_ptr = (e + 1) % N;
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int g, t, s0, bad;
    logic [W-1:0] d;
    logic [N-1:0] oh, aft;
    bit st;
    rand_ops();
    core_lat = 20;
    s0 = n_starts;
    t = 0;
    do begin
      @(negedge sys_clk);
      req_valid = 4'b1000;
      rsp_ready = '0;
      #3;
      t++;
    end while (req_ready == '0 && t < 20);
    @(negedge sys_clk);
    req_valid = '0;
    t = 0;
    while (n_starts == s0 && t < 50) begin
      @(negedge sys_clk);
      #3;
      t++;
    end
    @(negedge sys_clk);
    #3;
    n_vec++;
    if (n_starts - s0 !== 1 || busy !== 1'b1) begin n_err++; $display("FAIL midrst_wait: got starts=%0d busy=%b expected 1/1", n_starts - s0, busy); end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #3;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #3;
    m_ptr = 0;
    n_vec++;
    if (busy !== 1'b0 || core_start !== 1'b0 || rsp_valid !== '0 || req_ready !== '0 || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL midrst_ctrl: busy=%b start=%b rsp_valid=%b req_ready=%b grant_id=%0d expected 0", busy, core_start, rsp_valid, req_ready, grant_id);
    end
    n_vec++;
    if (core_a !== '0 || core_b !== '0 || rsp_data !== '0) begin n_err++; $display("FAIL midrst_data: a=%0d b=%0d data=%0d expected 0", core_a, core_b, rsp_data); end
    bad = 0;
    repeat (30) begin
      @(negedge sys_clk);
      #3;
      if (rsp_valid !== '0 || busy !== 1'b0) bad++;
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL midrst_late_done: got %0d bad cycles expected 0", bad); end
    core_lat = 2;
    do_txn(4'hF, 4'h0, 0, g, d, oh, aft, st);
    n_vec++;
    if (g !== exp_grant(4'hF)) begin n_err++; $display("FAIL midrst_ptr: got %0d expected %0d", g, exp_grant(4'hF)); end
    n_vec++;
    if (d !== gcd_ref(op_a[0], op_b[0])) begin n_err++; $display("FAIL midrst_data2: got %0d expected %0d", d, gcd_ref(op_a[0], op_b[0])); end
    m_ptr = (exp_grant(4'hF) + 1) % N;
  endtask

  task automatic test_zero();
    int g, e, s0, exp_starts;
    logic [W-1:0] d;
    logic [N-1:0] oh, aft;
    bit st;
    logic [W-1:0] za [3];
    logic [W-1:0] zb [3];
    logic [W-1:0] zr [3];
    logic [N-1:0] mask;
    za[0] = 0;  zb[0] = 35; zr[0] = 35;
    za[1] = 12; zb[1] = 0;  zr[1] = 12;
    za[2] = 0;  zb[2] = 0;  zr[2] = 0;
`ifdef GCD_ARB_ZERO_BYPASS_EN
    exp_starts = 0;
`else
    exp_starts = 1;
`endif
    for (int k = 0; k < 3; k++) begin
      mask = '0;
      mask[$urandom_range(0, N - 1)] = 1'b1;
      e = exp_grant(mask);
      op_a[e] = za[k];
      op_b[e] = zb[k];
      drive_ops();
      s0 = n_starts;
      do_txn(mask, 4'h0, 0, g, d, oh, aft, st);
      n_vec++;
      if (g !== e || d !== zr[k]) begin n_err++; $display("FAIL zero_rsp[%0d]: got grant=%0d data=%0d expected %0d/%0d", k, g, d, e, zr[k]); end
      n_vec++;
      if (n_starts - s0 !== exp_starts) begin n_err++; $display("FAIL zero_starts[%0d]: got %0d expected %0d", k, n_starts - s0, exp_starts); end
      m_ptr = (e + 1) % N;
    end
  endtask

  task automatic test_random();
    int g, e, dly;
    logic [W-1:0] d;
    logic [N-1:0] oh, aft, mask, hold;
    bit st;
    for (int k = 0; k < 25; k++) begin
      rand_ops();
      mask = N'($urandom_range(1, (1 << N) - 1));
      hold = ($urandom_range(0, 1) == 1) ? mask : '0;
      core_lat = $urandom_range(0, 4);
      dly = $urandom_range(0, 3);
      e = exp_grant(mask);
      do_txn(mask, hold, dly, g, d, oh, aft, st);
      n_vec++;
      if (g !== e || oh !== N'(1 << e)) begin n_err++; $display("FAIL rand_grant[%0d]: got %0d/%b expected %0d", k, g, oh, e); end
      n_vec++;
      if (d !== gcd_ref(op_a[e], op_b[e]) || st !== 1'b1) begin
        n_err++;
        $display("FAIL rand_data[%0d]: got %0d stable=%0d expected %0d", k, d, st, gcd_ref(op_a[e], op_b[e]));
      end
      m_ptr = (e + 1) % N;
    end
    req_valid = '0;
    core_lat = 2;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_core_stall();
    test_resp_backpressure();
    test_reset_mid();
    test_zero();
    test_random();
    repeat (3) @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
